// File: rtl/fifo_status_pkg.sv
// Shared defaults and occupancy-count type for the FIFO pointer/status logic.
package fifo_status_pkg;

   localparam int unsigned MEM_SIZE_DEF = 4;
   localparam int unsigned PTR_L_DEF    = 3;

   typedef logic [PTR_L_DEF-1:0] occ_t;

   // Saturation limit of an occupancy count, truncated to the count width.
   function automatic occ_t occ_limit(input int unsigned mem_size);
      return occ_t'(mem_size);
   endfunction

endpackage

// File: rtl/fifo_status_occ_counter.sv
// Saturating up/down occupancy counter: pushes are dropped at MEM_SIZE, pops at 0.
module occ_counter
   import fifo_status_pkg::*;
#(
   parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
   parameter int unsigned PTR_L    = PTR_L_DEF
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             push,
   input  logic             pop,
   output logic [PTR_L-1:0] count
);

   localparam logic [PTR_L-1:0] CNT_MAX = PTR_L'(MEM_SIZE);

   logic [PTR_L-1:0] count_q, count_d;
   logic             wr_acc, rd_acc;

   always_comb begin
      wr_acc  = push && (count_q != CNT_MAX);
      rd_acc  = pop  && (count_q != '0);
      count_d = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + PTR_L'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - PTR_L'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fifo_status.sv
// FIFO occupancy tracker with threshold flags and sticky error flags.
// Error detection is built only when FIFO_STATUS_ERR_EN is defined.
module fifo_status
   import fifo_status_pkg::*;
#(
   parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
   parameter int unsigned PTR_L    = PTR_L_DEF
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             push,
   input  logic             pop,
   input  logic [PTR_L-1:0] umbral_alto,
   input  logic [PTR_L-1:0] umbral_bajo,
   output logic [PTR_L-1:0] fifo_count,
   output logic             fifo_empty,
   output logic             fifo_full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic             err_overflow,
   output logic             err_underflow
);

   localparam logic [PTR_L-1:0] CNT_MAX = PTR_L'(MEM_SIZE);

   occ_counter #(
      .MEM_SIZE (MEM_SIZE),
      .PTR_L    (PTR_L)
   ) u_occ (
      .clk     (clk),
      .reset_L (reset_L),
      .push    (push),
      .pop     (pop),
      .count   (fifo_count)
   );

   always_comb begin
      fifo_empty   = (fifo_count == '0);
      fifo_full    = (fifo_count == CNT_MAX);
      almost_empty = (fifo_count <= umbral_bajo);
      almost_full  = (fifo_count >= umbral_alto);
   end

`ifdef FIFO_STATUS_ERR_EN
   logic ovf_q, ovf_d, unf_q, unf_d;

   // A simultaneous pop/push rescues the opposite side, so it is not an error.
   always_comb begin
      ovf_d = ovf_q || (push && fifo_full  && !pop);
      unf_d = unf_q || (pop  && fifo_empty && !push);
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign err_overflow  = ovf_q;
   assign err_underflow = unf_q;
`else
   assign err_overflow  = 1'b0;
   assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_status.sv
// Self-checking bench for fifo_status: directed vector table, threshold corner
// sequence, then randomized traffic against an arithmetic occupancy model.
module tb_fifo_status;

   localparam int unsigned MEM   = 4;
   localparam int unsigned PTR_L = 3;
`ifdef FIFO_STATUS_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_L, push, pop;
   logic [PTR_L-1:0] umbral_alto, umbral_bajo, fifo_count;
   logic             fifo_empty, fifo_full, almost_empty, almost_full;
   logic             err_overflow, err_underflow;

   int checks = 0;
   int errors = 0;

   fifo_status #(.MEM_SIZE(MEM), .PTR_L(PTR_L)) dut (
      .clk           (clk),
      .reset_L       (reset_L),
      .push          (push),
      .pop           (pop),
      .umbral_alto   (umbral_alto),
      .umbral_bajo   (umbral_bajo),
      .fifo_count    (fifo_count),
      .fifo_empty    (fifo_empty),
      .fifo_full     (fifo_full),
      .almost_empty  (almost_empty),
      .almost_full   (almost_full),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       rst_n, psh, pp;
      int       ua, ub;
      int       cnt;
      bit       emp, ful, ae, af, ov, un;  // ov/un: value when error detection is built
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input int cnt, input bit emp, input bit ful,
                          input bit ae, input bit af, input bit ov, input bit un);
      chk({tag, ".count"},    int'(fifo_count),    cnt);
      chk({tag, ".empty"},    int'(fifo_empty),    int'(emp));
      chk({tag, ".full"},     int'(fifo_full),     int'(ful));
      chk({tag, ".aempty"},   int'(almost_empty),  int'(ae));
      chk({tag, ".afull"},    int'(almost_full),   int'(af));
      chk({tag, ".overflow"}, int'(err_overflow),  int'(ov));
      chk({tag, ".underflow"},int'(err_underflow), int'(un));
   endtask

   task automatic drive(input bit r, input bit p, input bit q, input int ua, input int ub);
      reset_L     = r;
      push        = p;
      pop         = q;
      umbral_alto = PTR_L'(ua);
      umbral_bajo = PTR_L'(ub);
   endtask

   vec_t vecs[$];

   initial begin
      int  m_cnt;
      bit  m_ov, m_un;
      bit  r, p, q;
      int  ua, ub;

      drive(1'b1, 1'b0, 1'b0, 3, 1);
      //        rst psh pop ua ub  cnt emp ful ae af ov un
      vecs.push_back('{0, 1, 0, 3, 1, 0, 1, 0, 1, 0, 0, 0}); // reset wins over push
      vecs.push_back('{1, 1, 0, 3, 1, 1, 0, 0, 1, 0, 0, 0});
      vecs.push_back('{1, 1, 0, 3, 1, 2, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1, 1, 0, 3, 1, 3, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{1, 1, 0, 3, 1, 4, 0, 1, 0, 1, 0, 0});
      vecs.push_back('{1, 1, 0, 3, 1, 4, 0, 1, 0, 1, 1, 0}); // push while full
      vecs.push_back('{1, 0, 0, 4, 4, 4, 0, 1, 1, 1, 1, 0}); // sticky, thresholds at MEM
      vecs.push_back('{1, 1, 1, 3, 1, 3, 0, 0, 0, 1, 1, 0}); // full: pop accepted
      vecs.push_back('{0, 1, 1, 3, 1, 0, 1, 0, 1, 0, 0, 0});
      vecs.push_back('{1, 1, 1, 3, 1, 1, 0, 0, 1, 0, 0, 0}); // empty: push accepted
      vecs.push_back('{1, 0, 1, 3, 1, 0, 1, 0, 1, 0, 0, 0});
      vecs.push_back('{1, 0, 1, 3, 1, 0, 1, 0, 1, 0, 0, 1}); // pop while empty
      vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1}); // umbral_alto=0
      vecs.push_back('{0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0});
      vecs.push_back('{1, 1, 0, 2, 1, 1, 0, 0, 1, 0, 0, 0});
      vecs.push_back('{1, 1, 0, 2, 1, 2, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{1, 1, 0, 3, 1, 3, 0, 0, 0, 1, 0, 0});
      vecs.push_back('{0, 1, 0, 3, 1, 0, 1, 0, 1, 0, 0, 0}); // mid-run reset + push

      foreach (vecs[i]) begin
         drive(vecs[i].rst_n, vecs[i].psh, vecs[i].pp, vecs[i].ua, vecs[i].ub);
         @(posedge clk); #1;
         chk_all($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful,
                 vecs[i].ae, vecs[i].af, vecs[i].ov & ERR_EN, vecs[i].un & ERR_EN);
      end

      // Threshold change must show on almost_empty without a clock edge.
      drive(1'b1, 1'b1, 1'b0, 3, 1);
      repeat (2) @(posedge clk);
      #1;
      drive(1'b1, 1'b0, 1'b0, 3, 1);
      #1;
      chk("thr.count2", int'(fifo_count), 2);
      chk("thr.ae_ub1", int'(almost_empty), 0);
      umbral_bajo = PTR_L'(2);
      #1;
      chk("thr.ae_ub2", int'(almost_empty), 1);

      // Randomized traffic against an occupancy model.
      drive(1'b0, 1'b0, 1'b0, 3, 1);
      @(posedge clk); #1;
      m_cnt = 0; m_ov = 0; m_un = 0;
      for (int n = 0; n < 500; n++) begin
         r  = ($urandom_range(31) != 0);
         p  = $urandom_range(1);
         q  = $urandom_range(1);
         ua = $urandom_range((1 << PTR_L) - 1);
         ub = $urandom_range((1 << PTR_L) - 1);
         drive(r, p, q, ua, ub);
         if (!r) begin
            m_cnt = 0; m_ov = 0; m_un = 0;
         end else begin
            if (ERR_EN && p && !q && m_cnt == MEM) m_ov = 1;
            if (ERR_EN && q && !p && m_cnt == 0)   m_un = 1;
            m_cnt = m_cnt + ((p && m_cnt < MEM) ? 1 : 0) - ((q && m_cnt > 0) ? 1 : 0);
         end
         @(posedge clk); #1;
         chk_all($sformatf("rnd%0d", n), m_cnt, m_cnt == 0, m_cnt == MEM,
                 m_cnt <= ub, m_cnt >= ua, m_ov, m_un);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
